// File: rtl/scan_cmd_pkg.sv
// Shared types and constants for the PS/2 scan-code command decoder.
// KEY_TABLE maps band-select index to its make code; 8'h00 marks unused slots.
package scan_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Index 0 is the leftmost element: T, B, M, A, then reserved slots.
    localparam logic [0:7][7:0] KEY_TABLE = {
        8'h2C, 8'h32, 8'h3A, 8'h1C,
        8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/scan_key_lut.sv
// Combinational first-match lookup of a scan code in the active key table.
// Code 0x00 never hits, so reserved slots stay invisible.
module scan_key_lut
    import scan_cmd_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [7:0]       code,
    output logic             hit,
    output logic [SEL_W-1:0] idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns hit/idx and no latch is inferred.
        hit = 1'b0;
        idx = '0;
        // Scanning downward lets the lowest matching index win on duplicates.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (code != 8'h00 && code == KEY_TABLE[i]) begin
                hit = 1'b1;
                idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/scan_cmd_decoder.sv
// PS/2 scan-code decoder: tracks E0/F0 prefixes, maps make codes to a held
// band select and emits press/repeat/release/error pulses one cycle later.
module scan_cmd_decoder
    import scan_cmd_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             repeat_p,
    output logic             release_p,
    output logic             key_held,
    output logic             err_p
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] sel_q;       // also serves as the held key index
    logic             key_held_q;
    logic             sel_valid_q;
    logic             repeat_q;
    logic             release_q;
    logic             err_q;

    logic             lut_hit;
    logic [SEL_W-1:0] lut_idx;
    logic             is_held_key;

    scan_key_lut #(
        .NUM_KEYS(NUM_KEYS),
        .SEL_W   (SEL_W)
    ) u_lut (
        .code(data_in),
        .hit (lut_hit),
        .idx (lut_idx)
    );

    assign is_held_key = lut_hit && key_held_q && (sel_q == lut_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            key_held_q  <= 1'b0;
            sel_valid_q <= 1'b0;
            repeat_q    <= 1'b0;
            release_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulses default low and are set for one cycle.
            sel_valid_q <= 1'b0;
            repeat_q    <= 1'b0;
            release_q   <= 1'b0;
            err_q       <= 1'b0;

            if (data_valid) begin
                cnt_q <= '0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (data_in == SC_EXT) begin
                            state_q <= ST_EXT;
                        end else if (data_in == SC_BRK) begin
                            state_q <= ST_BRK;
                        end else if (is_held_key) begin
                            repeat_q <= 1'b1;
                        end else if (lut_hit) begin
                            sel_q       <= lut_idx;
                            key_held_q  <= 1'b1;
                            sel_valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_EXT: begin
                        state_q <= (data_in == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_BRK: begin
                        state_q <= ST_IDLE;
                        if (data_in == SC_EXT || data_in == SC_BRK) begin
                            err_q <= 1'b1;
                        end else if (is_held_key) begin
                            key_held_q <= 1'b0;
                            release_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (state_q != ST_IDLE) begin
                // Abandon a stalled prefix silently; the byte wins if both coincide.
                if (cnt_q == CNT_LAST) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign repeat_p  = repeat_q;
    assign release_p = release_q;
    assign key_held  = key_held_q;
    assign err_p     = err_q;

endmodule
